window_buffer_3x3: RTL
======================

Name: window_buffer_3x3

Overview:
- Streaming 3x3 sliding-window generator for raster-order image pixels.
- Holds two previous image rows in line buffers plus a 3x3 register window.
- Sits directly upstream of the weighted_average stencil stage: win_data drives its i_rd_data, and win_valid drives its t.
- One window is produced per accepted pixel once the window lies fully inside the frame. There is no padding.

Parameters:
- ELEMENT_WIDTH, 32, pixel bit width.
- IMG_WIDTH, 16, pixels per row (columns); must be >= 3.
- IMG_HEIGHT, 16, rows per frame; must be >= 3.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- t  input  1  start-of-frame pulse; pixel (0,0) may arrive on the same cycle.
- in_valid  input  1  in_data holds a pixel this cycle.
- in_data  input  ELEMENT_WIDTH  pixel value, raster order (row-major).
- win_valid  output  1  one-cycle pulse: win_data holds a complete window.
- win_data  output  ELEMENT_WIDTH x [2:0][2:0] (unpacked)  window; [0][*] is the oldest row, [*][0] is the leftmost column, [2][2] is the newest pixel.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- Reset values: state IDLE, col=0, row=0, win_valid=0, frame_done=0, all win_data=0. Line buffer contents are don't-care and are not reset.
- State IDLE:
  - in_valid is ignored.
  - t moves to RUN with col=0, row=0. If in_valid is also high that cycle, the pixel is accepted as (0,0).
- State RUN, on each accepted pixel (in_valid=1):
  - Shift the window left by one column. Column 2 is loaded from {line1[col], line0[col], in_data} for rows 0, 1, 2 respectively.
  - Update line buffers: line1[col]<=line0[col], line0[col]<=in_data.
  - col increments. When col reaches IMG_WIDTH-1 it wraps to 0 and row increments.
- Cycles with in_valid=0 in RUN: no state change, win_valid=0.
- Window output:
  - win_valid=1 exactly one cycle after accepting pixel (r,c) with r>=2 and c>=2; win_data is updated the same cycle.
  - win_data is held stable until the next accepted pixel.
  - Windows per frame: (IMG_HEIGHT-2)*(IMG_WIDTH-2).
  - Windows that straddle a row boundary (c<2) are never flagged valid.
- End of frame:
  - Accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1) pulses frame_done=1 on the next cycle, coincident with the final win_valid.
  - The state returns to IDLE in that same cycle, so t may be asserted on the frame_done cycle to start the next frame back-to-back.
- t while in RUN: restart. col and row are cleared and any in_valid that cycle is accepted as (0,0). No frame_done is issued for the aborted frame. Stale line buffer data is masked by the row>=2 gating.
- rst mid-frame: immediate return to reset values. An in-flight win_valid or frame_done is suppressed.
- Throughput: one pixel per cycle with no stalls; no backpressure exists.
- Arithmetic: col is clog2(IMG_WIDTH) bits and row is clog2(IMG_HEIGHT) bits, compared against the parameters. Pixel data passes through unmodified.

Test Plan:
- 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4): t with in_valid, then 16 consecutive pixels with value r*4+c.
  - First win_valid comes the cycle after pixel 10, with rows {0,1,2},{4,5,6},{8,9,10}.
  - Exactly 4 pulses, with centers 5, 6, 9, 10.
  - frame_done coincides with the last pulse, whose window is {5,6,7},{9,10,11},{13,14,15}.
- Same frame with in_valid low on every other cycle: identical window sequence and values; win_valid never asserts in a gap cycle.
- in_valid pulses before any t (IDLE): no win_valid and no frame_done.
- Mid-frame t after 9 pixels, then a full 16-pixel frame of values 100+r*4+c:
  - First window {100,101,102},{104,105,106},{108,109,110}, with no old data present.
  - Exactly one frame_done.
- rst asserted on the cycle after pixel 10 is accepted: win_valid=0 and win_data=0 the next cycle; a subsequent in_valid without t produces nothing.
- Back-to-back frames with t on the frame_done cycle: the second frame yields 4 correct windows and a second frame_done exactly 16 accepted pixels later.

Source files
------------

// File: rtl/window_buffer_3x3_if.sv
// Stream interface of the 3x3 window generator: raster pixels in, windows out.
// master drives pixels and consumes windows; slave is the window generator.
interface window_buffer_3x3_if #(
    parameter int ELEMENT_WIDTH = 32
);
    logic                     t;
    logic                     in_valid;
    logic [ELEMENT_WIDTH-1:0] in_data;
    logic                     win_valid;
    logic [ELEMENT_WIDTH-1:0] win_data [2:0][2:0];
    logic                     frame_done;

    modport master (
        output t, in_valid, in_data,
        input  win_valid, win_data, frame_done
    );

    modport slave (
        input  t, in_valid, in_data,
        output win_valid, win_data, frame_done
    );
endinterface

// File: rtl/window_buffer_3x3.sv
// Streaming 3x3 sliding-window generator over raster-order pixels, built from two
// row line buffers plus a 3x3 register window; only fully in-frame windows are flagged.
module window_buffer_3x3 #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int IMG_WIDTH     = 16,
    parameter int IMG_HEIGHT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    window_buffer_3x3_if.slave  bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            col_q, col_d, col_eff_s;
    logic [RW-1:0]            row_q, row_d, row_eff_s;
    logic                     accept_s;
    logic                     last_s;
    logic                     win_valid_q, win_valid_d;
    logic                     frame_done_q, frame_done_d;
    logic [ELEMENT_WIDTH-1:0] win_q   [2:0][2:0];
    logic [ELEMENT_WIDTH-1:0] line0_q [IMG_WIDTH];
    logic [ELEMENT_WIDTH-1:0] line1_q [IMG_WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: t always (re)starts a frame, the last accepted pixel ends it
    always_comb begin
        state_d = state_q;
        if (bus.t) begin
            state_d = RUN;
        end else if (accept_s && last_s) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // Acceptance, position tracking and output flags; a t cycle behaves as position (0,0)
    always_comb begin
        col_eff_s    = bus.t ? '0 : col_q;
        row_eff_s    = bus.t ? '0 : row_q;
        accept_s     = bus.in_valid && (bus.t || (state_q == RUN));
        last_s       = (row_eff_s == ROW_LAST) && (col_eff_s == COL_LAST);
        col_d        = col_eff_s;
        row_d        = row_eff_s;
        win_valid_d  = accept_s && (row_eff_s >= ROW_TWO) && (col_eff_s >= COL_TWO);
        frame_done_d = accept_s && last_s;
        if (accept_s) begin
            if (col_eff_s == COL_LAST) begin
                col_d = '0;
                if (last_s) begin
                    row_d = '0;
                end else begin
                    row_d = row_eff_s + RW'(1);
                end
            end else begin
                col_d = col_eff_s + CW'(1);
                row_d = row_eff_s;
            end
        end else begin
            col_d = col_eff_s;
            row_d = row_eff_s;
        end
    end

    // Position counters, output flags and the 3x3 window register
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            if (accept_s) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= line1_q[col_eff_s];
                win_q[1][2] <= line0_q[col_eff_s];
                win_q[2][2] <= bus.in_data;
            end
        end
    end

    // Line buffers need no reset: stale rows are masked by the row>=2 gating
    always_ff @(posedge clk) begin
        if (accept_s) begin
            line1_q[col_eff_s] <= line0_q[col_eff_s];
            line0_q[col_eff_s] <= bus.in_data;
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign bus.win_data[r][c] = win_q[r][c];
        end
    end
endmodule
